// File: rtl/serializer_multi_ddr_pkg.sv
// Shared constants and helpers for the multi-lane DDR serializer.
// Holds the default idle fill word, the legal word-width bounds and the lane rotate function.
package serializer_multi_ddr_pkg;

    localparam logic [15:0] IDLE_WORD_DEFAULT = 16'h0354;
    localparam int          RATIO_MIN         = 4;
    localparam int          RATIO_MAX         = 16;

    // Rotate the low 'width' bits of 'word' right by 'amount' (amount < width).
    function automatic logic [15:0] rotate_right(input logic [15:0] word,
                                                 input int          width,
                                                 input int          amount);
        logic [31:0] mask;
        logic [31:0] base;
        logic [31:0] doubled;
        mask    = (32'd1 << width) - 32'd1;
        base    = {16'd0, word} & mask;
        doubled = base | (base << width);
        return 16'((doubled >> amount) & mask);
    endfunction

endpackage

// File: rtl/ddio_out.sv
// Single-bit double-data-rate output cell: both bits are captured on the rising edge,
// the rising-edge bit drives the pin in the high phase and the falling-edge bit in the low phase.
module ddio_out (
    input  logic serial_clk,
    input  logic d_rise,
    input  logic d_fall,
    output logic q
);

    logic rise_q;
    logic fall_q;

    always_ff @(posedge serial_clk) begin
        rise_q <= d_rise;
        fall_q <= d_fall;
    end

    // The clock itself selects the phase, as the dedicated output-mux of an IO cell would.
    assign q = serial_clk ? rise_q : fall_q;

endmodule

// File: rtl/ser_lane.sv
// One serial lane: bit-slip offset, rotated word load, shift register and the p/n output cells.
// Load and fill decisions come from the shared slot logic in the top level.
module ser_lane
    import serializer_multi_ddr_pkg::*;
#(
    parameter int          RATIO     = 10,
    parameter int          DDR       = 1,
    parameter logic [15:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
    input  logic             serial_clk,
    input  logic             rst,
    input  logic             load,
    input  logic             par_valid,
    input  logic             bitslip,
    input  logic [RATIO-1:0] par_word,
    output logic             serial_p,
    output logic             serial_n
);

    localparam int               OFF_W = $clog2(RATIO);
    localparam int               STEP  = (DDR != 0) ? 2 : 1;
    localparam logic [RATIO-1:0] FILL  = IDLE_WORD[RATIO-1:0];

    logic [RATIO-1:0] shift_reg;
    logic [RATIO-1:0] next_word;
    logic [RATIO-1:0] rotated;
    logic [OFF_W-1:0] offset;
    logic             d_rise;
    logic             d_fall;

    assign next_word = par_valid ? par_word : FILL;
    assign rotated   = RATIO'(rotate_right(16'(next_word), RATIO, int'(offset)));

    // The load uses the offset held before this edge, so a slip on a load slot affects the next word.
    always_ff @(posedge serial_clk) begin
        if (rst) begin
            shift_reg <= FILL;
            offset    <= '0;
        end else begin
            if (load) begin
                shift_reg <= rotated;
            end else begin
                shift_reg <= shift_reg >> STEP;
            end
            if (bitslip) begin
                offset <= (offset == OFF_W'(RATIO - 1)) ? '0 : offset + OFF_W'(1);
            end
        end
    end

    assign d_rise = shift_reg[0];
    assign d_fall = (DDR != 0) ? shift_reg[1] : shift_reg[0];

    ddio_out u_ddio_p (
        .serial_clk (serial_clk),
        .d_rise     (d_rise),
        .d_fall     (d_fall),
        .q          (serial_p)
    );

    ddio_out u_ddio_n (
        .serial_clk (serial_clk),
        .d_rise     (~d_rise),
        .d_fall     (~d_fall),
        .q          (serial_n)
    );

endmodule

// File: rtl/serializer_multi_ddr.sv
// Multi-lane parallel-to-serial converter with per-lane bit slip and DDR or SDR output.
// The slot counter, load handshake and underflow counter are shared by all lanes.
module serializer_multi_ddr
    import serializer_multi_ddr_pkg::*;
#(
    parameter int          LANES     = 3,
    parameter int          RATIO     = 10,
    parameter int          DDR       = 1,
    parameter logic [15:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
    input  logic                   serial_clk,
    input  logic                   rst,
    input  logic [LANES*RATIO-1:0] par_data,
    input  logic                   par_valid,
    output logic                   par_ready,
    input  logic [LANES-1:0]       bitslip,
    output logic                   frame_start,
    output logic [15:0]            underflow_cnt,
    output logic [LANES-1:0]       serial_data_p,
    output logic [LANES-1:0]       serial_data_n
);

    localparam int W     = (DDR != 0) ? RATIO / 2 : RATIO;
    localparam int CNT_W = $clog2(W);

    logic [CNT_W-1:0] slot_cnt;
    logic             load_slot;

    assign load_slot = (slot_cnt == CNT_W'(W - 1));
    assign par_ready = load_slot;

    // A load slot without valid data still loads the idle word, and is counted as an underflow.
    always_ff @(posedge serial_clk) begin
        if (rst) begin
            slot_cnt      <= '0;
            frame_start   <= 1'b0;
            underflow_cnt <= 16'd0;
        end else begin
            slot_cnt    <= load_slot ? '0 : slot_cnt + CNT_W'(1);
            frame_start <= load_slot;
            if (load_slot && !par_valid && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ser_lane #(
            .RATIO     (RATIO),
            .DDR       (DDR),
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .serial_clk (serial_clk),
            .rst        (rst),
            .load       (load_slot),
            .par_valid  (par_valid),
            .bitslip    (bitslip[i]),
            .par_word   (par_data[i*RATIO +: RATIO]),
            .serial_p   (serial_data_p[i]),
            .serial_n   (serial_data_n[i])
        );
    end

endmodule
